// File: rtl/preadd532_pkg.sv
// Shared types and sizing helpers for the pre-add/multiply arbiter.
package preadd532_pkg;

    // Upper bound on requester count (8) fixes the tag id field width.
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int res_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/rr_arb532.sv
// Combinational round-robin grant: search starts at i_ptr and wraps; one-hot grant plus encoded index.
module rr_arb532
    import preadd532_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_en,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [ID_W-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = ID_W'((int'(i_ptr) + k) % N_REQ);
            if (i_en && !o_any && i_req[w_j]) begin
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/preadd532_arb.sv
// Round-robin arbiter in front of one shared (a+b)*c datapath, with result routing by tag.
// Optional per-requester grant counters when PREADD532_ARB_STATS_EN is defined.
module preadd532_arb
    import preadd532_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int W      = 16,
    parameter int DP_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req_vld,
    output logic [N_REQ-1:0]           req_rdy,
    input  logic [N_REQ-1:0][W-1:0]    req_a,
    input  logic [N_REQ-1:0][W-1:0]    req_b,
    input  logic [N_REQ-1:0][W-1:0]    req_c,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [res_w(W)-1:0]        rsp_data,
    output logic [W-1:0]               dp_in_a,
    output logic [W-1:0]               dp_in_b,
    output logic [W-1:0]               dp_in_c,
    output logic                       dp_in_vld,
    input  logic [res_w(W)-1:0]        dp_out,
    input  logic                       dp_out_vld,
`ifdef PREADD532_ARB_STATS_EN
    output logic [N_REQ-1:0][15:0]     grant_cnt,
`endif
    output logic                       err
);

    localparam int ID_W = id_w(N_REQ);

    logic [ID_W-1:0]  r_ptr;
    logic [W-1:0]     r_dp_a;
    logic [W-1:0]     r_dp_b;
    logic [W-1:0]     r_dp_c;
    tag_t             r_issue;
    tag_t             r_tag [DP_LAT];
    logic             r_err;

    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_any;
    logic [ID_W-1:0]  w_ptr_next;
    tag_t             w_tag_out;
    logic             w_rsp_fire;
    logic             w_mismatch;

    // Reset gates the grant so req_rdy reads 0 while rst_n is held low.
    rr_arb532 #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .i_req (req_vld),
        .i_en  (en & rst_n),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    assign w_ptr_next = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_dp_a  <= '0;
            r_dp_b  <= '0;
            r_dp_c  <= '0;
            r_issue <= '0;
            for (int s = 0; s < DP_LAT; s++) begin
                r_tag[s] <= '0;
            end
            r_err   <= 1'b0;
        end else begin
            r_issue.vld <= w_any;
            r_issue.id  <= MAX_ID_W'(w_gnt_idx);
            if (w_any) begin
                r_ptr  <= w_ptr_next;
                r_dp_a <= req_a[w_gnt_idx];
                r_dp_b <= req_b[w_gnt_idx];
                r_dp_c <= req_c[w_gnt_idx];
            end
            // Tag stages shadow the datapath so stage DP_LAT-1 lines up with dp_out_vld.
            r_tag[0] <= r_issue;
            for (int s = 1; s < DP_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_tag_out  = r_tag[DP_LAT-1];
    assign w_rsp_fire = dp_out_vld & w_tag_out.vld;
    assign w_mismatch = dp_out_vld ^ w_tag_out.vld;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign rsp_vld[gi] = w_rsp_fire & (w_tag_out.id == MAX_ID_W'(gi));
        end
    endgenerate

    assign req_rdy   = w_gnt;
    assign rsp_data  = dp_out;
    assign dp_in_a   = r_dp_a;
    assign dp_in_b   = r_dp_b;
    assign dp_in_c   = r_dp_c;
    assign dp_in_vld = r_issue.vld;
    assign err       = r_err;

`ifdef PREADD532_ARB_STATS_EN
    logic [15:0] r_grant_cnt [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_grant_cnt[gi] <= '0;
                end else if (w_gnt[gi] && (r_grant_cnt[gi] != 16'hFFFF)) begin
                    r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
                end
            end
            assign grant_cnt[gi] = r_grant_cnt[gi];
        end
    endgenerate
`endif

endmodule
